// File: rtl/chart_pkg.sv
// Shared types for the chart sequencer: ROM entry layout, FSM states, end marker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chart_pkg;

    // One ROM word: upper nibble is the arrow mask, lower nibble the beat delay.
    typedef struct packed {
        logic [3:0] arrows;
        logic [3:0] timing;
    } chart_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LAUNCH,
        DONE
    } chart_state_e;

    // An all-zero word terminates the chart.
    localparam logic [7:0] END_MARKER = 8'h00;

endpackage

// File: rtl/chart_wait_timer.sv
// Beat down-counter for one chart entry; expire flags the beat that takes it 1->0.
// Latency: load/decrement visible the cycle after; expire is combinational on en.
// Backpressure: none; en is already qualified by the caller (beat, not paused).
module chart_wait_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       expire
);

    logic [3:0] count;

    // Clear beats load, load beats decrement; never underflows below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign expire = en && (count == 4'd1);

endmodule

// File: rtl/chart_sequencer.sv
// Walks the chart ROM: waits each entry's beats, then launches its arrow mask.
// Latency: start -> FETCH next cycle; a timing-0 entry launches 2 cycles after start.
// Backpressure: launch held until launch_ready_i; beats seen during LAUNCH are dropped.
module chart_sequencer
    import chart_pkg::*;
#(
    parameter int ADDR_WIDTH_P = 3,
    parameter int LOOP_P       = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    pause_i,
    input  logic                    beat_i,
    output logic [ADDR_WIDTH_P-1:0] rd_addr_o,
    input  logic [7:0]              rd_data_i,
    output logic                    launch_valid_o,
    output logic [3:0]              launch_arrows_o,
    input  logic                    launch_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [ADDR_WIDTH_P-1:0] ADDR_LAST = '1;

    chart_state_e              state, state_next, adv_state;
    logic [ADDR_WIDTH_P-1:0]   addr, addr_next, adv_addr;
    logic [3:0]                arrows, arrows_next;
    chart_entry_t              entry;
    logic                      load, tick, expire;

    assign entry = chart_entry_t'(rd_data_i);
    assign tick  = (state == WAIT) && beat_i && !pause_i;

    chart_wait_timer u_timer (
        .clk      (clk_i),
        .rst_n    (reset_ni),
        .clear    (stop_i),
        .load     (load),
        .load_val (entry.timing),
        .en       (tick),
        .expire   (expire)
    );

    // Where the walk goes once the current entry is finished.
    always_comb begin
        adv_state = FETCH;
        adv_addr  = addr + ADDR_WIDTH_P'(1);
        if (addr == ADDR_LAST) begin
            if (LOOP_P != 0) begin
                adv_addr = '0;
            end else begin
                adv_state = DONE;
                adv_addr  = addr;
            end
        end
    end

    // Next-state, address and arrow-latch decisions; stop overrides everything.
    always_comb begin
        state_next  = state;
        addr_next   = addr;
        arrows_next = arrows;
        load        = 1'b0;
        if (stop_i) begin
            state_next = IDLE;
            addr_next  = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_next = FETCH;
                        addr_next  = '0;
                    end
                end
                FETCH: begin
                    load        = 1'b1;
                    arrows_next = entry.arrows;
                    if (rd_data_i == END_MARKER) begin
                        if (LOOP_P != 0) begin
                            addr_next = '0;
                        end else begin
                            state_next = DONE;
                        end
                    end else if (entry.timing == 4'd0) begin
                        if (entry.arrows != 4'd0) begin
                            state_next = LAUNCH;
                        end else begin
                            state_next = adv_state;
                            addr_next  = adv_addr;
                        end
                    end else begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (expire) begin
                        if (arrows != 4'd0) begin
                            state_next = LAUNCH;
                        end else begin
                            state_next = adv_state;
                            addr_next  = adv_addr;
                        end
                    end
                end
                LAUNCH: begin
                    if (launch_ready_i) begin
                        state_next = adv_state;
                        addr_next  = adv_addr;
                    end
                end
                default: begin
                    state_next = IDLE;
                    addr_next  = '0;
                end
            endcase
        end
    end

    // State, read address and latched arrow mask.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= IDLE;
            addr   <= '0;
            arrows <= 4'd0;
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            arrows <= arrows_next;
        end
    end

    assign rd_addr_o       = addr;
    assign launch_valid_o  = (state == LAUNCH);
    assign launch_arrows_o = arrows;
    assign busy_o          = (state == FETCH) || (state == WAIT) || (state == LAUNCH);
    assign done_o          = (state == DONE);

endmodule

// File: tb/tb_chart_sequencer.sv
// Scoreboard bench for chart_sequencer: a ROM-walk model queues expected launches,
// a negedge monitor checks arrows, address and effective beat count per handshake.
// Two instances cover the stop-at-end and looping variants.
module tb_chart_sequencer;

    typedef struct {
        logic [2:0] addr;
        logic [3:0] arrows;
        int         beats;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, stop, pause, beat, ready, sel;
    logic       start0, start1;
    logic [2:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, busy0, busy1, done0, done1;
    logic [3:0] arr0, arr1;
    logic [7:0] rom [8];

    logic       m_valid, m_busy, m_done;
    logic [3:0] m_arrows;
    logic [2:0] m_addr;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   eff = 0;
    bit   hs_seen = 1'b0;
    bit   beat_en = 1'b0;
    bit   rnd = 1'b0;

    assign start0 = start && !sel;
    assign start1 = start && sel;
    assign data0  = rom[addr0];
    assign data1  = rom[addr1];

    assign m_valid  = sel ? valid1 : valid0;
    assign m_busy   = sel ? busy1  : busy0;
    assign m_done   = sel ? done1  : done0;
    assign m_arrows = sel ? arr1   : arr0;
    assign m_addr   = sel ? addr1  : addr0;

    chart_sequencer #(.ADDR_WIDTH_P(3), .LOOP_P(0)) u0 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start0), .stop_i(stop),
        .pause_i(pause), .beat_i(beat), .rd_addr_o(addr0), .rd_data_i(data0),
        .launch_valid_o(valid0), .launch_arrows_o(arr0), .launch_ready_i(ready),
        .busy_o(busy0), .done_o(done0)
    );

    chart_sequencer #(.ADDR_WIDTH_P(3), .LOOP_P(1)) u1 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start1), .stop_i(stop),
        .pause_i(pause), .beat_i(beat), .rd_addr_o(addr1), .rd_data_i(data1),
        .launch_valid_o(valid1), .launch_arrows_o(arr1), .launch_ready_i(ready),
        .busy_o(busy1), .done_o(done1)
    );

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: beats that count are beat && !pause outside LAUNCH; check at each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (start) eff = 0;
            if (m_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_launch", int'(m_valid), 0);
                end else begin
                    chk("launch_arrows", int'(m_arrows), int'(q[0].arrows));
                    if (ready) begin
                        chk("launch_addr", int'(m_addr), int'(q[0].addr));
                        chk("launch_beats", eff, q[0].beats);
                        void'(q.pop_front());
                        eff = 0;
                    end
                end
            end else if (beat && !pause) begin
                eff++;
            end
            hs_seen = m_valid && ready;
        end else begin
            hs_seen = 1'b0;
        end
    end

    // Background beat generator with random ready/pause; never beats right after a handshake.
    initial begin
        int gap;
        gap = 3;
        forever begin
            @(posedge clk); #1;
            if (rnd) begin
                ready = ($urandom_range(0, 3) != 0);
                pause = ($urandom_range(0, 3) == 0);
            end
            if (beat_en) begin
                beat = 1'b0;
                if (gap > 0) gap--;
                else if (!hs_seen) begin
                    beat = 1'b1;
                    gap  = $urandom_range(3, 6);
                end
            end else begin
                gap = 3;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Reference: walk the ROM by the chart rules and queue every expected launch.
    task automatic build_model(input bit lp, input int max_launch, output logic [2:0] fa);
        int a, beats, n, steps;
        logic [7:0] ent;
        exp_t e;
        a = 0; beats = 0; n = 0; steps = 0;
        while (steps < 64 && n < max_launch) begin
            ent = rom[a];
            steps++;
            if (ent == 8'h00) begin
                if (lp) begin
                    a = 0;
                    continue;
                end
                break;
            end
            beats += int'(ent[3:0]);
            if (ent[7:4] != 4'h0) begin
                e.addr = 3'(a); e.arrows = ent[7:4]; e.beats = beats;
                q.push_back(e);
                beats = 0;
                n++;
            end
            if (a == 7) begin
                if (!lp) break;
                a = 0;
            end else begin
                a++;
            end
        end
        fa = 3'(a);
    endtask

    task automatic set_rom(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        rom[0] = e0; rom[1] = e1; rom[2] = e2;
    endtask

    task automatic rand_rom(input bit lp);
        int endpos;
        logic [3:0] a, t;
        endpos = lp ? 8 : $urandom_range(2, 8);
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(0, 15));
            t = 4'($urandom_range(0, 3));
            if (t == 4'd0 && a == 4'd0) t = 4'd1;
            rom[i] = {a, t};
        end
        if (rom[0][7:4] == 4'h0) rom[0] = {4'h8, rom[0][3:0]};
        if (endpos < 8) rom[endpos] = 8'h00;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic give_beat();
        repeat (2) @(posedge clk);
        #1 beat = 1'b1;
        @(posedge clk); #1 beat = 1'b0;
    endtask

    task automatic wait_q_empty(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", int'(m_done), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("valid_reached", int'(m_valid), 1);
    endtask

    task automatic run_chart(input bit lp, input int max_launch, input bit rand_mode, input bit lat_chk);
        logic [2:0] fa;
        sel = lp; beat_en = 1'b0; rnd = rand_mode;
        if (!rand_mode) begin ready = 1'b1; pause = 1'b0; end
        build_model(lp, max_launch, fa);
        pulse_start();
        @(negedge clk);
        chk("start_busy", int'(m_busy), 1);
        chk("start_done_drop", int'(m_done), 0);
        if (lat_chk) begin
            chk("fetch_valid", int'(m_valid), 0);
            @(negedge clk); chk("launch_latency", int'(m_valid), 1);
            @(negedge clk); chk("valid_drop", int'(m_valid), 0);
            chk("next_fetch_addr", int'(m_addr), 1);
        end
        beat_en = 1'b1;
        wait_q_empty(3000);
        if (!lp) begin
            wait_done(1000);
            chk("done_busy", int'(m_busy), 0);
            chk("done_addr", int'(m_addr), int'(fa));
        end else begin
            stop = 1'b1;
            @(posedge clk); #1 stop = 1'b0;
            q.delete();
        end
        beat_en = 1'b0; rnd = 1'b0;
        @(posedge clk); #1 beat = 1'b0; ready = 1'b1; pause = 1'b0;
    endtask

    initial begin
        logic [2:0] fa;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; beat = 1'b0;
        ready = 1'b1; sel = 1'b0;
        set_rom(8'h00, 8'h00, 8'h00);
        #12;
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_addr", int'(m_addr), 0);
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_done", int'(m_done), 0);
        chk("rst_arrows", int'(m_arrows), 0);
        rst_n = 1'b1;

        // Basic chart with latency checks, then a rest entry.
        set_rom(8'h10, 8'h23, 8'h00);
        run_chart(1'b0, 16, 1'b0, 1'b1);
        set_rom(8'h02, 8'h31, 8'h00);
        run_chart(1'b0, 16, 1'b0, 1'b0);

        // Backpressure: hold ready low 5 cycles in LAUNCH with stray beats.
        set_rom(8'h10, 8'h21, 8'h00);
        sel = 1'b0; ready = 1'b0;
        build_model(1'b0, 16, fa);
        pulse_start();
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 beat = (i % 2 == 0);
            @(negedge clk);
            chk("bp_valid", int'(m_valid), 1);
            chk("bp_arrows", int'(m_arrows), 1);
        end
        @(posedge clk); #1 beat = 1'b0; ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_addr_inc", int'(m_addr), 1);
        chk("bp_valid_drop", int'(m_valid), 0);
        beat_en = 1'b1;
        wait_q_empty(200);
        wait_done(200);
        chk("bp_done_addr", int'(m_addr), int'(fa));
        beat_en = 1'b0;
        @(posedge clk); #1 beat = 1'b0;

        // Full ROM of 8'h11: two laps when looping, DONE at address 7 otherwise.
        for (int i = 0; i < 8; i++) rom[i] = 8'h11;
        run_chart(1'b1, 16, 1'b0, 1'b0);
        run_chart(1'b0, 16, 1'b0, 1'b0);

        // Stop with simultaneous start mid-WAIT (count 2), then replay.
        set_rom(8'h13, 8'h10, 8'h00);
        sel = 1'b0; ready = 1'b1;
        pulse_start();
        give_beat();
        stop = 1'b1; start = 1'b1;
        @(posedge clk); #1 stop = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("stop_busy", int'(m_busy), 0);
        chk("stop_addr", int'(m_addr), 0);
        chk("stop_valid", int'(m_valid), 0);
        chk("stop_done", int'(m_done), 0);
        run_chart(1'b0, 16, 1'b0, 1'b0);

        // Pause across 3 beats delays the launch by exactly those beats.
        set_rom(8'h14, 8'h00, 8'h00);
        sel = 1'b0; ready = 1'b1;
        build_model(1'b0, 16, fa);
        pulse_start();
        @(posedge clk); #1 pause = 1'b1;
        repeat (3) give_beat();
        @(posedge clk); #1 pause = 1'b0;
        repeat (3) give_beat();
        repeat (2) @(negedge clk);
        chk("pause_delay", int'(m_valid), 0);
        give_beat();
        @(negedge clk);
        chk("pause_launch", int'(m_valid), 1);
        wait_q_empty(50);
        wait_done(50);
        chk("pause_done_addr", int'(m_addr), int'(fa));

        // Async reset in the middle of a held launch.
        set_rom(8'h10, 8'h00, 8'h00);
        sel = 1'b0; ready = 1'b0;
        build_model(1'b0, 16, fa);
        pulse_start();
        wait_valid(20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(m_valid), 0);
        chk("arst_arrows", int'(m_arrows), 0);
        chk("arst_addr", int'(m_addr), 0);
        chk("arst_busy", int'(m_busy), 0);
        chk("arst_done", int'(m_done), 0);
        @(negedge clk);
        chk("arst_hold_valid", int'(m_valid), 0);
        #2 rst_n = 1'b1; ready = 1'b1;
        q.delete();

        // Randomized charts, random ready/pause.
        for (int r = 0; r < 3; r++) begin
            rand_rom(1'b0);
            run_chart(1'b0, 16, 1'b1, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            rand_rom(1'b1);
            run_chart(1'b1, 10, 1'b1, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chart_sequencer.md
Name: chart_sequencer

Overview:
Controller that walks the chart ROM entry by entry. Each entry is {arrows[3:0], timing[3:0]}. The block waits `timing` beats, then hands the arrow mask to the arrow spawner over a valid/ready handshake, then advances the read address. It sits between the combinational chart ROM, the tempo/beat generator and the arrow spawner, and replaces the free-running counter_up address source.

Parameters:
ADDR_WIDTH_P, 3, ROM address width; depth = 2**ADDR_WIDTH_P entries.
LOOP_P, 0, 1 = restart at address 0 after the last entry or end marker; 0 = stop in DONE.

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
start_i  in  1  pulse; begin chart from address 0 (honoured in IDLE/DONE only)
stop_i  in  1  pulse; abort to IDLE from any state
pause_i  in  1  level; freezes beat counting
beat_i  in  1  one-cycle pulse per chart beat
rd_addr_o  out  ADDR_WIDTH_P  ROM read address
rd_data_i  in  8  ROM data {arrows, timing}; combinational, same cycle as rd_addr_o
launch_valid_o  out  1  arrow launch request
launch_arrows_o  out  4  arrow mask; stable while launch_valid_o=1
launch_ready_i  in  1  spawner accepts launch
busy_o  out  1  state is FETCH, WAIT or LAUNCH
done_o  out  1  level; chart finished (state DONE)

Behaviour:
- Reset (reset_ni=0, async): state=IDLE, rd_addr_o=0, launch_valid_o=0, launch_arrows_o=0, wait count=0, busy_o=0, done_o=0.
- States: IDLE, FETCH, WAIT, LAUNCH, DONE.
- IDLE/DONE, on start_i:
  - rd_addr_o<=0, go FETCH.
  - done_o drops the cycle after start_i.
- FETCH (one cycle): latch arrows_r<=rd_data_i[7:4], count<=rd_data_i[3:0].
  - rd_data_i==8'h00 is the end marker: go DONE, or with LOOP_P=1 set addr<=0 and go FETCH.
  - Else timing==0: go LAUNCH if arrows!=0, else advance.
  - Else go WAIT.
  - A beat_i in the FETCH cycle is ignored.
- WAIT:
  - On beat_i && !pause_i: count<=count-1.
  - On the beat that brings count 1->0: go LAUNCH if arrows_r!=0, else advance. An entry with arrows=0 is a rest: it consumes beats and issues no launch.
- LAUNCH:
  - launch_valid_o=1 and launch_arrows_o=arrows_r, held until launch_ready_i.
  - On handshake (valid&&ready): deassert next cycle, then advance.
  - beat_i is ignored in LAUNCH; backpressure delays the chart and beats are not banked.
- Advance:
  - If rd_addr_o is all ones: addr wraps to 0 when LOOP_P=1 (go FETCH), else go DONE with addr unchanged.
  - Otherwise addr<=addr+1, go FETCH.
- stop_i has highest priority: in any state, next cycle state=IDLE, launch_valid_o=0, addr=0.
  - stop_i and start_i in the same cycle: stop wins.
  - stop_i during a pending launch drops the launch.
- start_i while busy_o=1 is ignored.
- pause_i affects WAIT only. A pending LAUNCH still completes while paused.
- Latency from a start_i pulse at cycle 0, with entry 0 = 8'h10:
  - Cycle 1: FETCH.
  - Cycle 2: launch_valid_o=1.
  - With launch_ready_i=1, cycle 3: valid=0 and FETCH of addr 1.
- Count width is 4 bits, so at most 15 beats per entry.

Decomposition:
- Package chart_pkg:
  - typedef chart_entry_t struct packed {logic [3:0] arrows; logic [3:0] timing;}
  - enum chart_state_e {IDLE, FETCH, WAIT, LAUNCH, DONE}
  - localparam END_MARKER = 8'h00
- One sub-module, chart_wait_timer: 4-bit load/decrement-on-enable down-counter with an expire flag. Async active-low reset, clears when stop_i is asserted.

Test Plan:
- ROM {10,23,00}; start_i, beats every 4 cycles, ready=1:
  - arrows 0001 launched 2 cycles after start.
  - arrows 0010 launched after 3 further beats.
  - Then done_o=1, busy_o=0, rd_addr_o=2.
- ROM {02,31,00}: rest entry consumes 2 beats with launch_valid_o never high, then 0011 launched after 1 more beat.
- Backpressure: launch_ready_i=0 for 5 cycles during LAUNCH:
  - launch_valid_o=1 and launch_arrows_o stable all 5 cycles.
  - Extra beat_i pulses ignored.
  - Exactly one handshake, then addr increments by 1.
- Wrap with full ROM of 8'h11 and no end marker, LOOP_P=1:
  - After addr 7, the next FETCH is addr 0.
  - 16 launches observed over 2 laps.
- LOOP_P=0 with the same ROM: DONE after addr 7, addr stays 7.
- stop_i asserted mid-WAIT with count=2, start_i in the same cycle:
  - Next cycle IDLE, addr 0, valid 0.
  - A later start_i replays from entry 0.
- Async reset asserted mid-LAUNCH:
  - launch_valid_o=0 immediately, without waiting for a clock edge.
  - All outputs at their reset values while reset_ni=0.
- pause_i high across 3 beat_i pulses in WAIT: count unchanged, and the launch is delayed by exactly those beats.
